// File: rtl/serial_rotator_8_bit_if.sv
// Handshake bundle for the serial right rotator: job input on one side, result output on the other.
interface serial_rotator_8_bit_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data;
    logic [AMT_W-1:0] amt;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] shifted_data;
    logic             busy;

    modport master (
        output in_valid, data, amt, mode, out_ready,
        input  in_ready, out_valid, shifted_data, busy
    );

    modport slave (
        input  in_valid, data, amt, mode, out_ready,
        output in_ready, out_valid, shifted_data, busy
    );
endinterface

// File: rtl/serial_rotator_8_bit.sv
// Bit-serial right rotator / logical right shifter: one position per clock,
// result held under valid/ready backpressure until the consumer takes it.
module serial_rotator_8_bit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_rotator_8_bit_if.slave bus_if
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;

    logic             accept_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             busy_s;

    // In logical mode the vacated MSB is zero; otherwise the LSB wraps around.
    function automatic logic [WIDTH-1:0] shift_right_one(
        input logic [WIDTH-1:0] value,
        input logic             logical
    );
        return {(logical ? 1'b0 : value[0]), value[WIDTH-1:1]};
    endfunction

    assign accept_s = (state_q == IDLE) && bus_if.in_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = (bus_if.amt == {AMT_W{1'b0}}) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (count_q == AMT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (bus_if.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Working register, remaining count and latched mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= {WIDTH{1'b0}};
            count_q <= {AMT_W{1'b0}};
            mode_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end

    // Datapath next values; DONE and IDLE hold so the result stays visible
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    data_d  = bus_if.data;
                    count_d = bus_if.amt;
                    mode_d  = bus_if.mode;
                end else begin
                    data_d  = data_q;
                end
            end
            SHIFT: begin
                data_d  = shift_right_one(data_q, mode_q);
                count_d = count_q - AMT_W'(1);
            end
            DONE:    data_d = data_q;
            default: data_d = data_q;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            SHIFT: busy_s = 1'b1;
            DONE:  out_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
                busy_s      = 1'b1;
            end
        endcase
    end

    assign bus_if.in_ready     = in_ready_s;
    assign bus_if.out_valid    = out_valid_s;
    assign bus_if.busy         = busy_s;
    assign bus_if.shifted_data = data_q;

endmodule

// File: tb/tb_serial_rotator_8_bit.sv
// Directed bench for serial_rotator_8_bit with hand-computed expected results.
module tb_serial_rotator_8_bit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    serial_rotator_8_bit_if #(.WIDTH(8), .AMT_W(3)) rot_if ();

    serial_rotator_8_bit #(.WIDTH(8), .AMT_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (rot_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_job(input logic [7:0] d, input logic [2:0] a, input logic m);
        rot_if.data     = d;
        rot_if.amt      = a;
        rot_if.mode     = m;
        rot_if.in_valid = 1'b1;
        check_val("accept_ready", 32'(rot_if.in_ready), 32'd1);
        tick();
        rot_if.in_valid = 1'b0;
        // scramble inputs to show the job is isolated from them
        rot_if.data     = 8'h3C;
        rot_if.amt      = 3'd5;
        rot_if.mode     = ~m;
    endtask

    task automatic wait_result(input string tag, input int exp_lat, input logic [7:0] exp_data);
        int cyc;
        cyc = 0;
        while (!rot_if.out_valid && cyc < 20) begin
            check_val({tag, "_busy"}, 32'(rot_if.busy), 32'd1);
            tick();
            cyc++;
        end
        check_val({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check_val({tag, "_data"}, 32'(rot_if.shifted_data), 32'(exp_data));
    endtask

    task automatic release_result(input logic [7:0] exp_data);
        rot_if.out_ready = 1'b1;
        tick();
        rot_if.out_ready = 1'b0;
        check_val("rel_in_ready", 32'(rot_if.in_ready), 32'd1);
        check_val("rel_out_valid", 32'(rot_if.out_valid), 32'd0);
        check_val("rel_busy", 32'(rot_if.busy), 32'd0);
        check_val("rel_hold_data", 32'(rot_if.shifted_data), 32'(exp_data));
    endtask

    initial begin
        int pulses;
        n_checks         = 0;
        n_errors         = 0;
        rst              = 1'b1;
        rot_if.in_valid  = 1'b0;
        rot_if.data      = 8'h00;
        rot_if.amt       = 3'd0;
        rot_if.mode      = 1'b0;
        rot_if.out_ready = 1'b0;
        tick();
        tick();
        check_val("rst_data", 32'(rot_if.shifted_data), 32'h00);
        check_val("rst_out_valid", 32'(rot_if.out_valid), 32'd0);
        check_val("rst_busy", 32'(rot_if.busy), 32'd0);
        check_val("rst_in_ready", 32'(rot_if.in_ready), 32'd1);
        rst = 1'b0;
        tick();

        accept_job(8'b1010_1010, 3'd1, 1'b0);
        wait_result("ror1", 1, 8'b0101_0101);
        release_result(8'b0101_0101);

        accept_job(8'b1111_0000, 3'd4, 1'b0);
        wait_result("ror4", 4, 8'b0000_1111);
        release_result(8'b0000_1111);

        accept_job(8'b0000_1111, 3'd7, 1'b0);
        wait_result("ror7", 7, 8'b0001_1110);
        release_result(8'b0001_1110);

        accept_job(8'b0000_1111, 3'd7, 1'b1);
        wait_result("lsr7", 7, 8'b0000_0000);
        release_result(8'b0000_0000);

        accept_job(8'b1100_1001, 3'd3, 1'b1);
        wait_result("lsr3", 3, 8'b0001_1001);
        release_result(8'b0001_1001);

        accept_job(8'b1010_1010, 3'd0, 1'b0);
        check_val("amt0_out_valid", 32'(rot_if.out_valid), 32'd1);
        wait_result("amt0", 0, 8'b1010_1010);
        release_result(8'b1010_1010);

        // backpressure with a competing job held on the input
        accept_job(8'b1010_1010, 3'd1, 1'b0);
        wait_result("bp", 1, 8'b0101_0101);
        rot_if.in_valid = 1'b1;
        rot_if.data     = 8'hFF;
        rot_if.amt      = 3'd1;
        rot_if.mode     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_in_ready", 32'(rot_if.in_ready), 32'd0);
            check_val("bp_out_valid", 32'(rot_if.out_valid), 32'd1);
            check_val("bp_data", 32'(rot_if.shifted_data), 32'h55);
        end
        rot_if.out_ready = 1'b1;
        tick();
        rot_if.out_ready = 1'b0;
        check_val("bp_idle_ready", 32'(rot_if.in_ready), 32'd1);
        check_val("bp_no_same_cycle_accept", 32'(rot_if.busy), 32'd0);
        tick();
        rot_if.in_valid = 1'b0;
        check_val("bp_next_accepted", 32'(rot_if.busy), 32'd1);
        wait_result("bp_next", 1, 8'h7F);
        release_result(8'h7F);

        // asynchronous reset in the middle of a shift
        accept_job(8'b1111_0000, 3'd6, 1'b0);
        tick();
        tick();
        tick();
        check_val("mid_busy_before", 32'(rot_if.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_data", 32'(rot_if.shifted_data), 32'h00);
        check_val("mid_rst_out_valid", 32'(rot_if.out_valid), 32'd0);
        check_val("mid_rst_busy", 32'(rot_if.busy), 32'd0);
        check_val("mid_rst_in_ready", 32'(rot_if.in_ready), 32'd1);
        tick();
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rot_if.out_valid) pulses++;
        end
        check_val("mid_rst_no_pulse", 32'(pulses), 32'd0);
        check_val("mid_rst_idle", 32'(rot_if.in_ready), 32'd1);

        // a job after the reset still works
        accept_job(8'b1000_0001, 3'd2, 1'b0);
        wait_result("post_rst", 2, 8'b0110_0000);
        release_result(8'b0110_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_rotator_8_bit.md
# serial_rotator_8_bit

Sequential right-direction counterpart to the team's combinational 8-bit barrel rotator. It accepts a word and a shift amount over a valid/ready handshake. It then shifts one bit position per clock, rotating right or doing a logical right shift. It presents the result over a valid/ready output handshake. It is used where a left rotation must be undone, or where a single-bit datapath replaces a full barrel shifter.

## Interface
- WIDTH, 8, data word width
- AMT_W, 3, shift amount width (max amount 2^AMT_W-1, must be < WIDTH)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  data/amt/mode presented
- in_ready  out  1  block can accept a new job
- data  in  WIDTH  word to shift
- amt  in  AMT_W  number of bit positions to shift right
- mode  in  1  0 = rotate right, 1 = logical shift right (zero fill at MSB)
- out_valid  out  1  shifted_data holds the completed result
- out_ready  in  1  consumer takes the result
- shifted_data  out  WIDTH  working/result register
- busy  out  1  job in progress or result pending

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- in_ready = (state == IDLE). busy = (state != IDLE). out_valid = (state == DONE).
- IDLE: an edge with in_valid && in_ready accepts the job.
  - The accept edge loads shifted_data <= data and count <= amt, and latches mode.
  - The next state is DONE if amt == 0, otherwise SHIFT.
- SHIFT: each edge shifts shifted_data right by one position.
  - Rotate mode: the new MSB is the old LSB.
  - Logical mode: the new MSB is 0.
  - The same edge does count <= count - 1. When count == 1 at the edge, the next state is DONE.
- DONE: shifted_data and out_valid are held stable. An edge with out_ready = 1 returns to IDLE. shifted_data keeps the last result in IDLE.
- data, amt, mode and in_valid are ignored outside IDLE. Input changes during SHIFT/DONE do not affect the job.
- No accept happens in the same cycle as the DONE to IDLE transition. The next job can be accepted one cycle later.
- Width rules:
  - count is AMT_W bits.
  - Rotation is modulo WIDTH, so a rotate-right by k equals a rotate-left by WIDTH-k.
  - A logical shift of k clears the top k bits.

## Timing
- Reset values: state IDLE, shifted_data 0, count 0, latched mode 0, out_valid 0, busy 0, in_ready 1.
  - in_ready reads 1 during reset, but no accept occurs while rst = 1.
- Reset asserted mid-SHIFT or mid-DONE takes effect immediately, with no clock needed:
  - out_valid and busy drop to 0.
  - shifted_data goes to 0.
  - The job is discarded.
- Latency, with the accept edge as E0:
  - out_valid rises after edge E0 + amt.
  - amt = 0 gives out_valid high the cycle right after acceptance.
  - amt = k gives k SHIFT cycles.
- Throughput: one job per amt + 2 cycles minimum (accept, k shifts, one DONE cycle with out_ready = 1, then IDLE).
- Output hold: while out_valid = 1 and out_ready = 0, shifted_data and out_valid must not change.
- Intermediate shifted_data values during SHIFT are visible but undefined for consumers. Only values with out_valid = 1 are meaningful.

## Test plan
- Reset: assert rst for 2 cycles mid-simulation -> shifted_data = 00000000, out_valid = 0, busy = 0, in_ready = 1; deassert and confirm IDLE.
- Rotate by 1 and 4:
  - data 10101010, amt 001, mode 0 -> out_valid 1 cycle after accept, shifted_data = 01010101.
  - data 11110000, amt 100, mode 0 -> busy for 4 SHIFT cycles, then shifted_data = 00001111.
- Max amount, both modes, data 00001111, amt 111:
  - mode 0 -> 00011110 after 7 cycles (equals rotate-left by 1).
  - mode 1 -> 00000000.
- Zero amount: data 10101010, amt 000 -> out_valid high the cycle after accept, shifted_data = 10101010, no SHIFT state entered.
- Backpressure and input isolation:
  - After a result, hold out_ready = 0 for 5 cycles while driving in_valid = 1 with data 11111111 -> in_ready = 0, and shifted_data/out_valid stay unchanged.
  - Raise out_ready -> IDLE next cycle, and the new job is accepted one cycle later.
- Reset mid-operation: accept data 11110000, amt 110, mode 0, then assert rst after 3 SHIFT cycles -> outputs return to reset values immediately, and no out_valid pulse occurs after release.
